// File: rtl/ann_pkg.sv
// ann_pkg: shared state enum, index widths and size defaults for the layer sequencer.
package ann_pkg;
  localparam int IN_W = 7;
  localparam int NODE_W = 4;
  localparam int MAX_INPUTS_DEF = 16;
  localparam int MAX_NODES_DEF = 10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } seq_state_t;
  function automatic logic [IN_W-1:0] clamp_cnt(input logic [IN_W-1:0] v, input int mx);
    return (v > IN_W'(mx)) ? IN_W'(mx) : v;
  endfunction
endpackage

// File: rtl/ann_index_counter.sv
// ann_index_counter: clearable enabled counter that wraps after a programmable terminal value.
module ann_index_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == term_i;
  assign cnt_o = cnt_q;
  always_comb cnt_d = clr_i ? '0 : en_i ? (last_o ? '0 : cnt_q + W'(1)) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ann_layer_sequencer.sv
// ann_layer_sequencer: walks nodes x inputs of one FC layer, issuing coefficient reads and MAC control.
// Optional ANN_SEQ_BIAS_EN adds one bias fetch per node and a bias_sel output.
module ann_layer_sequencer
  import ann_pkg::*;
#(
  parameter int MAX_INPUTS = MAX_INPUTS_DEF,
  parameter int MAX_NODES  = MAX_NODES_DEF,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   num_inputs,
  input  logic [NODE_W-1:0] num_nodes,
  input  logic [ADDR_W-1:0] coef_base,
  input  logic              coef_ready,
  output logic              coef_rd,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_clear,
  output logic              mac_en,
  output logic [IN_W-1:0]   input_sel,
  output logic [NODE_W-1:0] node_sel,
  output logic              node_write,
  output logic              busy,
`ifdef ANN_SEQ_BIAS_EN
  output logic              bias_sel,
`endif
  output logic              done
);
`ifdef ANN_SEQ_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  seq_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IN_W-1:0] in_term_q, in_term_d, input_sel_q, input_sel_d, in_cnt, ni_c;
  logic [NODE_W-1:0] node_term_q, node_term_d, nn_c;
  logic mac_en_q, bias_q, in_last, node_last, accept, go;
  assign ni_c = clamp_cnt(num_inputs, MAX_INPUTS);
  assign nn_c = NODE_W'(clamp_cnt(IN_W'(num_nodes), MAX_NODES));
  assign accept = (state_q == S_FETCH) && coef_ready;
  assign go = (state_q == S_IDLE) && start;
  // With bias the last fetch index equals num_inputs, so the terminal is not decremented.
  assign in_term_d = go ? ni_c - (BIAS_EN ? IN_W'(0) : IN_W'(1)) : in_term_q;
  assign node_term_d = go ? nn_c - NODE_W'(1) : node_term_q;
  assign addr_d = go ? coef_base : accept ? addr_q + ADDR_W'(1) : addr_q;
  assign input_sel_d = accept ? in_cnt : input_sel_q;
  always_comb begin
    state_d = state_q;
    coef_rd = 1'b0;
    mac_clear = 1'b0;
    node_write = 1'b0;
    done = 1'b0;
    busy = state_q != S_IDLE;
    case (state_q)
      S_IDLE:  if (start) state_d = (ni_c == '0 || nn_c == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: begin
        mac_clear = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        coef_rd = 1'b1;
        if (accept && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        node_write = 1'b1;
        state_d = node_last ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      in_term_q <= '0;
      node_term_q <= '0;
      input_sel_q <= '0;
      mac_en_q <= 1'b0;
      bias_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      in_term_q <= in_term_d;
      node_term_q <= node_term_d;
      input_sel_q <= input_sel_d;
      mac_en_q <= accept;
      bias_q <= accept && in_last && BIAS_EN;
    end
  ann_index_counter #(.W(IN_W)) u_in_cnt (
    .clk(clk), .rst(rst), .clr_i(state_q == S_CLEAR), .en_i(accept),
    .term_i(in_term_q), .cnt_o(in_cnt), .last_o(in_last)
  );
  ann_index_counter #(.W(NODE_W)) u_node_cnt (
    .clk(clk), .rst(rst), .clr_i(state_q == S_IDLE), .en_i(state_q == S_WRITE && !node_last),
    .term_i(node_term_q), .cnt_o(node_sel), .last_o(node_last)
  );
  assign coef_addr = addr_q;
  assign mac_en = mac_en_q;
  assign input_sel = input_sel_q;
`ifdef ANN_SEQ_BIAS_EN
  assign bias_sel = bias_q;
`else
  logic unused_bias;
  assign unused_bias = bias_q;
`endif
endmodule
